countdown_ctrl: RTL and testbench
=================================

# countdown_ctrl

Sequencing controller for the lab's N-bit countdown display path. It holds a loadable reload value and prescales the board clock into decrement ticks. Software-style start, pause, resume and abort controls drive an IDLE/RUN/PAUSED/DONE state machine. The registered count it produces feeds the two seven-segment converters, and it raises a one-cycle expiry pulse.

## Interface
Parameters:
- N, 6, count width in bits; count range 0 .. 2^N-1
- DIV, 50_000_000, clk cycles per decrement tick; legal range ≥ 2

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk)
- start  in  1  level, sampled each cycle; begins or resumes counting
- pause  in  1  level; freezes count while RUN
- abort  in  1  level; returns to IDLE, count restored to reload value
- load_en  in  1  writes load_val into reload register and count
- load_val  in  N  new reload value
- auto_reload  in  1  on expiry: 1 = reload and keep running, 0 = stop in DONE
- count  out  N  current count value, registered
- state  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3
- busy  out  1  high in RUN or PAUSED
- expired  out  1  one-cycle pulse in the cycle after count reaches 0

## Operation
- Reset values:
  - count = 2^N-1
  - reload register = 2^N-1
  - state = IDLE
  - prescaler = 0
  - busy = 0
  - expired = 0
- Per-cycle priority: abort > load_en > start > pause > tick.
- abort, any state: go to IDLE; count ← reload; prescaler ← 0.
- load_en:
  - Accepted only in IDLE, PAUSED and DONE. Ignored in RUN.
  - reload ← load_val; count ← load_val; state is unchanged, except DONE → IDLE.
- start:
  - IDLE with count ≠ 0 → RUN, prescaler ← 0.
  - IDLE with count = 0 → ignored.
  - PAUSED → RUN, prescaler retained.
  - DONE → RUN with count ← reload and prescaler ← 0, provided reload ≠ 0.
- pause in RUN → PAUSED; count and prescaler frozen.
- While start and pause are both high in RUN, the block stays in RUN, because start outranks pause.
- RUN prescaler: increments every cycle, wraps DIV-1 → 0; tick = (prescaler == DIV-1).
- On tick:
  - count > 1: count ← count-1.
  - count == 1: count ← 0.
    - auto_reload=0: state → DONE.
    - auto_reload=1: count ← reload instead of 0; state stays RUN. If reload == 0, state → DONE.
  - In both count == 1 cases, expired asserts for exactly the next cycle.
- Arithmetic is unsigned N-bit. A decrement never wraps below 0.
- busy = (state == RUN) || (state == PAUSED), combinational from the state register.

## Timing
- Latency from a start edge to RUN is 1 cycle. The first decrement lands DIV cycles after RUN is entered.
- With reload = R, the time from start to expired is R·DIV + 1 cycles.
- expired is registered: it goes high the cycle after the final tick and stays high for 1 cycle.
- Paused time adds exactly the number of cycles spent in PAUSED. Prescaler phase is preserved across a pause.
- Reset mid-count: all outputs return to reset values asynchronously. Counting does not resume on release.
- abort on the same cycle as a final tick: abort wins and expired stays 0.
- DIV changes are elaboration-time only.

## Structure
- Shared package countdown_pkg holds:
  - typedef enum logic [1:0] cd_state_t {IDLE, RUN, PAUSED, DONE}
  - function max_count(N) returning 2^N-1
- Sub-module tick_gen (parameter DIV) contains:
  - inputs clk, reset, en, clr
  - output tick, plus the prescaler counter of width $clog2(DIV)
- countdown_ctrl instantiates one tick_gen. The top level feeds count into the existing seven-segment converters.

## Test plan
Bench parameters: N=6, DIV=4.
- Reset release: count=63, state=0, busy=0, expired=0. Apply start → state=1, and count reads 62 after 4 cycles.
- load_val=3, load_en, start, auto_reload=0: count sequence 3,2,1,0 at 4-cycle spacing. Then expired is high for 1 cycle, state=3, busy=0, and the total time from start to expired is 13 cycles.
- Reload=2, auto_reload=1: count sequence 2,1,2,1,… while staying in RUN. expired pulses every 8 cycles.
- Reload=5: run 6 cycles, pause 10 cycles, resume. count holds 4 during the pause, and the next decrement comes 2 cycles after resume.
- Pause and start high together in RUN → state stays RUN. load_en in RUN → count is unaffected.
- abort on the cycle of the final tick → state=0, count=reload, expired stays 0. Separately, assert reset mid-RUN → count=63 immediately.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown display controller.
package countdown_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } cd_state_t;

   function automatic logic [31:0] max_count(input int unsigned n);
      return (32'd1 << n) - 32'd1;
   endfunction

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// Prescaler: divides clk into one tick every DIV enabled cycles.
module tick_gen #(
   parameter int DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
      end
   end

   assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown sequencer: reload register, run/pause/done FSM, expiry pulse.
module countdown_ctrl
   import countdown_pkg::*;
#(
   parameter int N   = 6,
   parameter int DIV = 50_000_000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         pause,
   input  logic         abort,
   input  logic         load_en,
   input  logic [N-1:0] load_val,
   input  logic         auto_reload,
   output logic [N-1:0] count,
   output logic [1:0]   state,
   output logic         busy,
   output logic         expired
);

   localparam logic [N-1:0] MAXC = N'(max_count(N));

   cd_state_t    r_state;
   logic [N-1:0] r_count;
   logic [N-1:0] r_reload;
   logic         r_expired;

   logic w_load_ok;
   logic w_fresh;
   logic w_en;
   logic w_clr;
   logic w_tick;

   assign w_load_ok = load_en && (r_state != RUN);

   // Entries into RUN that restart the prescaler phase.
   assign w_fresh = !abort && !w_load_ok && start &&
                    (((r_state == IDLE) && (r_count != '0)) ||
                     ((r_state == DONE) && (r_reload != '0)));

   assign w_clr = abort || w_fresh;
   assign w_en  = !abort && (r_state == RUN) && !(pause && !start);

   tick_gen #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (w_en),
      .clr   (w_clr),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_count   <= MAXC;
         r_reload  <= MAXC;
         r_expired <= 1'b0;
      end else begin
         r_expired <= 1'b0;
         if (abort) begin
            r_state <= IDLE;
            r_count <= r_reload;
         end else if (w_load_ok) begin
            r_reload <= load_val;
            r_count  <= load_val;
            if (r_state == DONE) r_state <= IDLE;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (start && (r_count != '0)) r_state <= RUN;
               end
               PAUSED: begin
                  if (start) r_state <= RUN;
               end
               DONE: begin
                  if (start && (r_reload != '0)) begin
                     r_state <= RUN;
                     r_count <= r_reload;
                  end
               end
               RUN: begin
                  if (pause && !start) begin
                     r_state <= PAUSED;
                  end else if (w_tick) begin
                     if (r_count > N'(1)) begin
                        r_count <= r_count - N'(1);
                     end else if (r_count == N'(1)) begin
                        r_expired <= 1'b1;
                        if (auto_reload) begin
                           r_count <= r_reload;
                           if (r_reload == '0) r_state <= DONE;
                        end else begin
                           r_count <= '0;
                           r_state <= DONE;
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

   assign count   = r_count;
   assign state   = r_state;
   assign busy    = (r_state == RUN) || (r_state == PAUSED);
   assign expired = r_expired;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed plus randomized checks of countdown_ctrl against a cycle model.
module tb_countdown_ctrl;

   localparam int N   = 6;
   localparam int DIV = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         pause = 1'b0;
   logic         abort = 1'b0;
   logic         load_en = 1'b0;
   logic [N-1:0] load_val = '0;
   logic         auto_reload = 1'b0;
   logic [N-1:0] count;
   logic [1:0]   state;
   logic         busy;
   logic         expired;

   int checks = 0;
   int errors = 0;

   // model: state code, count, reload, prescaler phase, expiry flag
   int ms, mc, mr, mp;
   int me;

   countdown_ctrl #(.N(N), .DIV(DIV)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pause       (pause),
      .abort       (abort),
      .load_en     (load_en),
      .load_val    (load_val),
      .auto_reload (auto_reload),
      .count       (count),
      .state       (state),
      .busy        (busy),
      .expired     (expired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      ms = 0; mc = 63; mr = 63; mp = 0; me = 0;
   endtask

   task automatic mstep();
      int ns, nc, nr, np, ne;
      ns = ms; nc = mc; nr = mr; np = mp; ne = 0;
      if (abort) begin
         ns = 0; nc = mr; np = 0;
      end else if (load_en && ms != 1) begin
         nr = load_val; nc = load_val;
         if (ms == 3) ns = 0;
      end else if (start && ms == 0) begin
         if (mc != 0) begin ns = 1; np = 0; end
      end else if (start && ms == 2) begin
         ns = 1;
      end else if (start && ms == 3) begin
         if (mr != 0) begin ns = 1; nc = mr; np = 0; end
      end else if (pause && !start && ms == 1) begin
         ns = 2;
      end else if (ms == 1) begin
         np = (mp + 1) % DIV;
         if (mp == DIV - 1 && mc >= 1) begin
            nc = mc - 1;
            if (nc == 0) begin
               ne = 1;
               if (auto_reload) nc = mr;
               if (!auto_reload || mr == 0) ns = 3;
            end
         end
      end
      ms = ns; mc = nc; mr = nr; mp = np; me = ne;
   endtask

   task automatic cyc();
      @(posedge clk);
      mstep();
      #1;
      chk("count", 32'(count), 32'(mc));
      chk("state", 32'(state), 32'(ms));
      chk("busy", 32'(busy), 32'((ms == 1 || ms == 2) ? 1 : 0));
      chk("expired", 32'(expired), 32'(me));
   endtask

   task automatic clear_inputs();
      start = 0; pause = 0; abort = 0; load_en = 0;
   endtask

   initial begin
      int n;
      int first;
      mreset();
      #12 reset = 1'b1;
      #1;
      chk("rst_count", 32'(count), 32'd63);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_expired", 32'(expired), 32'd0);
      cyc();

      // first start from reset value
      start = 1; cyc(); start = 0;
      chk("start_state", 32'(state), 32'd1);
      repeat (4) cyc();
      chk("first_dec", 32'(count), 32'd62);

      // reload 3, no auto reload: expiry after 13 cycles
      abort = 1; cyc(); abort = 0;
      load_val = 3; load_en = 1; cyc(); load_en = 0;
      auto_reload = 0; start = 1;
      n = 0;
      while (expired !== 1'b1 && n < 40) begin
         cyc(); start = 0; n++;
         if (n == 4) chk("seq3", 32'(count), 32'd3);
         if (n == 5) chk("seq2", 32'(count), 32'd2);
         if (n == 9) chk("seq1", 32'(count), 32'd1);
      end
      chk("latency", 32'(n), 32'd13);
      chk("done_count", 32'(count), 32'd0);
      chk("done_state", 32'(state), 32'd3);
      chk("done_busy", 32'(busy), 32'd0);
      cyc();
      chk("exp_width", 32'(expired), 32'd0);

      // auto reload with reload 2
      load_val = 2; load_en = 1; cyc(); load_en = 0;
      auto_reload = 1; start = 1; cyc(); start = 0;
      n = 0;
      while (expired !== 1'b1 && n < 40) begin cyc(); n++; end
      first = n;
      n = 0;
      do begin cyc(); n++; end while (expired !== 1'b1 && n < 40);
      chk("auto_gap", 32'(n), 32'd8);
      chk("auto_state", 32'(state), 32'd1);
      chk("auto_count", 32'(count), 32'd2);
      chk("auto_first", 32'(first < 40), 32'd1);

      // pause with phase retention
      abort = 1; cyc(); abort = 0;
      auto_reload = 0;
      load_val = 5; load_en = 1; cyc(); load_en = 0;
      start = 1; cyc(); start = 0;
      repeat (6) cyc();
      pause = 1;
      repeat (10) cyc();
      chk("pause_count", 32'(count), 32'd4);
      chk("pause_state", 32'(state), 32'd2);
      pause = 0; start = 1; cyc(); start = 0;
      n = 0;
      while (count !== 6'd3 && n < 20) begin cyc(); n++; end
      chk("resume_dec", 32'(n), 32'd2);

      // start outranks pause; load ignored in RUN
      start = 1; pause = 1;
      repeat (3) cyc();
      chk("start_pause", 32'(state), 32'd1);
      clear_inputs();
      load_val = 9; load_en = 1; cyc(); load_en = 0;
      chk("ld_run", 32'(count == 6'd9), 32'd0);
      cyc();

      // abort on the final tick
      abort = 1; cyc(); abort = 0;
      load_val = 1; load_en = 1; cyc(); load_en = 0;
      start = 1; cyc(); start = 0;
      repeat (3) cyc();
      abort = 1; cyc(); abort = 0;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_count", 32'(count), 32'd1);
      chk("abort_exp", 32'(expired), 32'd0);
      cyc();
      chk("abort_exp2", 32'(expired), 32'd0);

      // asynchronous reset mid-run
      load_val = 20; load_en = 1; cyc(); load_en = 0;
      start = 1; cyc(); start = 0;
      repeat (6) cyc();
      #2 reset = 0;
      #1;
      chk("arst_count", 32'(count), 32'd63);
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      mreset();
      #1 reset = 1;
      repeat (3) cyc();

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         abort   = ($urandom_range(0, 39) == 0);
         load_en = ($urandom_range(0, 14) == 0);
         start   = ($urandom_range(0, 5) == 0);
         pause   = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 19) == 0) auto_reload = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) load_val = N'($urandom_range(0, 63));
         else load_val = N'($urandom_range(0, 3));
         cyc();
      end
      clear_inputs();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
